// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// Per-edge priority: frozen, then branch redirect, then stall, then flush, then normal fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o
);

  // Word alignment: the low two bits of the PC are constant zero.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_plus4;

  // Only the word-address bits of the redirect target are used.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target_i[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d         = pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (!start_i) begin
      ifid_pc4_d   = 32'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (branch_i) begin
      // The word fetched this cycle is on the wrong path and is squashed.
      pc_d         = {branch_target_i[31:2], 2'b00};
      ifid_pc4_d   = 32'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (flush_i) begin
      pc_d         = pc_plus4;
      ifid_pc4_d   = 32'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      pc_d         = pc_plus4;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = imem_instr_i;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q         <= RESET_PC_ALIGNED;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // ifid_valid_o qualifies ifid_pc4_o/ifid_instr_o: 1 = real instruction, 0 = bubble.
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, branch, wrap, async reset, freeze and flush.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  if_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_instr_i    (imem_instr_i),
    .pc_o            (pc_o),
    .ifid_pc4_o      (ifid_pc4_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_valid_o    (ifid_valid_o)
  );

  // Instruction memory contents: three fixed words, everything else a tagged address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  always_comb imem_instr_i = imem_word(imem_addr_o);

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ctl(input logic st, input logic sl, input logic fl,
                         input logic br, input logic [31:0] tgt);
    start_i = st; stall_i = sl; flush_i = fl; branch_i = br; branch_target_i = tgt;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
    total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, 32'h0); end
    total++; if ({ifid_valid_o, ifid_instr_o, ifid_pc4_o} !== 65'h0) begin bad++;
      $display("FAIL reset_ifid got=%b/%h/%h exp=0/00000000/00000000", ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h11; exp_instr[1] = 32'h22; exp_instr[2] = 32'h33;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ifid_instr_o !== exp_instr[i] || ifid_pc4_o !== 32'(4*(i+1)) || ifid_valid_o !== 1'b1) begin bad++;
        $display("FAIL fetch_ifid%0d got=%b/%h/%h exp=1/%h/%h", i, ifid_valid_o, ifid_instr_o, ifid_pc4_o, exp_instr[i], 32'(4*(i+1))); end
      total++; if (pc_o !== 32'(4*(i+1))) begin bad++; $display("FAIL fetch_pc%0d got=%h exp=%h", i, pc_o, 32'(4*(i+1))); end
    end
  endtask

  task automatic test_stall();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (pc_o !== 32'h8 || ifid_instr_o !== 32'h22 || ifid_pc4_o !== 32'h8 || ifid_valid_o !== 1'b1) begin bad++;
        $display("FAIL stall_hold%0d got=%h/%b/%h/%h exp=00000008/1/00000022/00000008", i, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    total++; if (pc_o !== 32'hC || ifid_instr_o !== 32'h33 || ifid_pc4_o !== 32'hC || ifid_valid_o !== 1'b1) begin bad++;
      $display("FAIL stall_release got=%h/%b/%h/%h exp=0000000c/1/00000033/0000000c", pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h10);
      tick();
      total++; if (pc_o !== 32'h10) begin bad++; $display("FAIL branch_setup%0d got=%h exp=00000010", k, pc_o); end
      set_ctl(1'b1, k[0], 1'b0, 1'b1, 32'h43);
      tick();
      total++; if (pc_o !== 32'h40 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin bad++;
        $display("FAIL branch_redirect%0d got=%h/%b/%h/%h exp=00000040/0/00000000/00000000", k, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      total++; if (pc_o !== 32'h44 || ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'hC0DE_0040 || ifid_pc4_o !== 32'h44) begin bad++;
        $display("FAIL branch_target_fetch%0d got=%h/%b/%h/%h exp=00000044/1/c0de0040/00000044", k, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    end
  endtask

  task automatic test_wrap();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align got=%h exp=fffffffc", pc_o); end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    total++; if (pc_o !== 32'h0 || ifid_pc4_o !== 32'h0 || ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h3F21_FFFC) begin bad++;
      $display("FAIL wrap_fetch got=%h/%b/%h/%h exp=00000000/1/3f21fffc/00000000", pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
  endtask

  task automatic test_async_reset();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h1C);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    total++; if (pc_o !== 32'h20 || ifid_valid_o !== 1'b1) begin bad++;
      $display("FAIL areset_setup got=%h/%b exp=00000020/1", pc_o, ifid_valid_o); end
    #2 rst_i = 1'b0;
    #1;
    total++; if (pc_o !== 32'h0 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin bad++;
      $display("FAIL areset_immediate got=%h/%b/%h/%h exp=00000000/0/00000000/00000000", pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_o !== 32'h0 || ifid_valid_o !== 1'b0) begin bad++;
        $display("FAIL frozen%0d got=%h/%b exp=00000000/0", i, pc_o, ifid_valid_o); end
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    total++; if (pc_o !== 32'h4 || ifid_instr_o !== 32'h11 || ifid_valid_o !== 1'b1) begin bad++;
      $display("FAIL resume got=%h/%b/%h exp=00000004/1/00000011", pc_o, ifid_valid_o, ifid_instr_o); end
  endtask

  task automatic test_flush();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    total++; if (pc_o !== 32'h8 || ifid_valid_o !== 1'b1) begin bad++;
      $display("FAIL flush_setup got=%h/%b exp=00000008/1", pc_o, ifid_valid_o); end
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    total++; if (pc_o !== 32'hC || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin bad++;
      $display("FAIL flush_bubble got=%h/%b/%h/%h exp=0000000c/0/00000000/00000000", pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    total++; if (pc_o !== 32'h10 || ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'hC0DE_000C || ifid_pc4_o !== 32'h10) begin bad++;
      $display("FAIL flush_stall_hold got=%h/%b/%h/%h exp=00000010/1/c0de000c/00000010", pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_wrap();
    test_async_reset();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
